// File: rtl/vec_chunk_fifo_if.sv
// Chunk FIFO bus: producer-side write, consumer-side show-ahead read, status flags.
// The master drives writes/pops; the slave (the FIFO) drives data and status.
interface vec_chunk_fifo_if #(
  parameter int WorkingRegs = 4,
  parameter int NBits       = 16
);
  logic                                 wr_chunk;
  logic signed [WorkingRegs-1:0][NBits-1:0] wr_data;
  logic                                 rd_chunk;
  logic signed [WorkingRegs-1:0][NBits-1:0] rd_data;
  logic                                 vec_ready;
  logic                                 full;
  logic                                 overflow_err;
  logic                                 underflow_err;

  modport master (
    output wr_chunk, wr_data, rd_chunk,
    input  rd_data, vec_ready, full, overflow_err, underflow_err
  );

  modport slave (
    input  wr_chunk, wr_data, rd_chunk,
    output rd_data, vec_ready, full, overflow_err, underflow_err
  );
endinterface

// File: rtl/vec_chunk_fifo.sv
// Circular chunk FIFO that only releases whole vectors to the consumer.
// Define VEC_CHUNK_FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module vec_chunk_fifo #(
  parameter int InVecLength = 8,
  parameter int NBits       = 16,
  parameter int WorkingRegs = 4,
  parameter int DepthVecs   = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  vec_chunk_fifo_if.slave bus
);
  localparam int ChunksPerVec = (InVecLength + WorkingRegs - 1) / WorkingRegs;
  localparam int Total        = DepthVecs * ChunksPerVec;
  localparam int CntW         = $clog2(Total + 1);
  localparam int PtrW         = (Total > 1) ? $clog2(Total) : 1;
  localparam int IdxW         = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;

  localparam logic [PtrW-1:0] LastSlot = PtrW'(Total - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(ChunksPerVec - 1);
  localparam logic [CntW-1:0] TotalCnt = CntW'(Total);

  typedef logic signed [WorkingRegs-1:0][NBits-1:0] chunk_t;

  chunk_t          r_mem [Total];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
  logic [IdxW-1:0] r_wr_idx, r_rd_idx;
  logic [CntW-1:0] r_count, r_committed;
  logic            r_vec_ready, r_full;

  logic            w_has_vec, w_is_full, w_pop, w_push, w_commit, w_retire;
  logic [CntW-1:0] w_count_nxt, w_comm_nxt;

  // A pop is legal only from a committed vector, so it never reaches a partial one.
  assign w_has_vec = (r_committed != '0);
  assign w_is_full = (r_count == TotalCnt);
  assign w_pop     = bus.rd_chunk & w_has_vec;
  assign w_push    = bus.wr_chunk & (~w_is_full | w_pop);
  assign w_commit  = w_push & (r_wr_idx == LastIdx);
  assign w_retire  = w_pop & (r_rd_idx == LastIdx);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CntW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CntW'(1);
    w_comm_nxt = r_committed;
    if (w_commit && !w_retire)      w_comm_nxt = r_committed + CntW'(1);
    else if (w_retire && !w_commit) w_comm_nxt = r_committed - CntW'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_count     <= '0;
      r_committed <= '0;
      r_vec_ready <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LastSlot) ? '0 : r_wr_ptr + PtrW'(1);
        r_wr_idx <= (r_wr_idx == LastIdx) ? '0 : r_wr_idx + IdxW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LastSlot) ? '0 : r_rd_ptr + PtrW'(1);
        r_rd_idx <= (r_rd_idx == LastIdx) ? '0 : r_rd_idx + IdxW'(1);
      end
      r_count     <= w_count_nxt;
      r_committed <= w_comm_nxt;
      r_vec_ready <= (w_comm_nxt != '0);
      r_full      <= (w_count_nxt == TotalCnt);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  assign bus.rd_data   = r_mem[r_rd_ptr];
  assign bus.vec_ready = r_vec_ready;
  assign bus.full      = r_full;

`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
  logic r_ovf, r_unf;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (bus.wr_chunk && !w_push)   r_ovf <= 1'b1;
      if (bus.rd_chunk && !w_has_vec) r_unf <= 1'b1;
    end
  end
  assign bus.overflow_err  = r_ovf;
  assign bus.underflow_err = r_unf;
`else
  assign bus.overflow_err  = 1'b0;
  assign bus.underflow_err = 1'b0;
`endif
endmodule

// File: tb/tb_vec_chunk_fifo.sv
// Directed bench for vec_chunk_fifo at InVecLength=8, WorkingRegs=4, NBits=16, DepthVecs=2.
// Error-flag expectations follow whether VEC_CHUNK_FIFO_ERR_FLAGS_EN is defined.
module tb_vec_chunk_fifo;
  typedef logic signed [3:0][15:0] chunk_t;

`ifdef VEC_CHUNK_FIFO_ERR_FLAGS_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vec_chunk_fifo_if #(.WorkingRegs(4), .NBits(16)) bus ();

  vec_chunk_fifo #(.InVecLength(8), .NBits(16), .WorkingRegs(4), .DepthVecs(2)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  function automatic chunk_t mk(input int a, input int b, input int c, input int d);
    chunk_t r;
    r[0] = 16'(a); r[1] = 16'(b); r[2] = 16'(c); r[3] = 16'(d);
    return r;
  endfunction

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic step(input logic wr, input chunk_t d, input logic rd);
    bus.wr_chunk = wr; bus.wr_data = d; bus.rd_chunk = rd;
    @(posedge clk); #1;
    bus.wr_chunk = 1'b0; bus.rd_chunk = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.wr_chunk = 1'b0; bus.rd_chunk = 1'b0; bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL reset_vec_ready: got %b want 0", bus.vec_ready); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_err); end
    n_cmp++; if (bus.underflow_err !== 1'b0) begin n_err++; $display("FAIL reset_unf: got %b want 0", bus.underflow_err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    step(1'b1, mk(1,2,3,4), 1'b0);
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL basic_partial_ready: got %b want 0", bus.vec_ready); end
    step(1'b1, mk(5,6,7,8), 1'b0);
    n_cmp++; if (bus.vec_ready !== 1'b1) begin n_err++; $display("FAIL basic_commit_ready: got %b want 1", bus.vec_ready); end
    n_cmp++; if (bus.rd_data !== mk(1,2,3,4)) begin n_err++; $display("FAIL basic_head0: got %h want %h", bus.rd_data, mk(1,2,3,4)); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL basic_full: got %b want 0", bus.full); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.rd_data !== mk(5,6,7,8)) begin n_err++; $display("FAIL basic_head1: got %h want %h", bus.rd_data, mk(5,6,7,8)); end
    n_cmp++; if (bus.vec_ready !== 1'b1) begin n_err++; $display("FAIL basic_mid_ready: got %b want 1", bus.vec_ready); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL basic_retire_ready: got %b want 0", bus.vec_ready); end
  endtask

  task automatic test_overflow();
    chunk_t exp [4];
    do_reset();
    exp[0] = mk(11,12,13,14); exp[1] = mk(21,22,23,24);
    exp[2] = mk(31,32,33,34); exp[3] = mk(-1,-2,-3,-4);
    for (int i = 0; i < 4; i++) step(1'b1, exp[i], 1'b0);
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", bus.full); end
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL ovf_flag_before: got %b want 0", bus.overflow_err); end
    step(1'b1, mk(9,9,9,9), 1'b0);
    n_cmp++; if (bus.overflow_err !== ERR_EN) begin n_err++; $display("FAIL ovf_flag: got %b want %b", bus.overflow_err, ERR_EN); end
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL ovf_full_after_drop: got %b want 1", bus.full); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.rd_data !== exp[i]) begin n_err++; $display("FAIL ovf_read%0d: got %h want %h", i, bus.rd_data, exp[i]); end
      step(1'b0, '0, 1'b1);
    end
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL ovf_drained_ready: got %b want 0", bus.vec_ready); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL ovf_drained_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.overflow_err !== ERR_EN) begin n_err++; $display("FAIL ovf_sticky: got %b want %b", bus.overflow_err, ERR_EN); end
  endtask

  task automatic test_underflow();
    do_reset();
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL unf_ovf_cleared: got %b want 0", bus.overflow_err); end
    step(1'b1, mk(100,200,300,400), 1'b0);
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL unf_ready: got %b want 0", bus.vec_ready); end
    n_cmp++; if (bus.underflow_err !== ERR_EN) begin n_err++; $display("FAIL unf_flag: got %b want %b", bus.underflow_err, ERR_EN); end
    step(1'b1, mk(500,600,700,800), 1'b0);
    n_cmp++; if (bus.vec_ready !== 1'b1) begin n_err++; $display("FAIL unf_commit_ready: got %b want 1", bus.vec_ready); end
    n_cmp++; if (bus.rd_data !== mk(100,200,300,400)) begin n_err++; $display("FAIL unf_ptr_kept: got %h want %h", bus.rd_data, mk(100,200,300,400)); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.rd_data !== mk(500,600,700,800)) begin n_err++; $display("FAIL unf_second: got %h want %h", bus.rd_data, mk(500,600,700,800)); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL unf_drained: got %b want 0", bus.vec_ready); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, mk(1,1,1,1), 1'b0);
    step(1'b1, mk(2,2,2,2), 1'b0);
    step(1'b1, mk(3,3,3,3), 1'b0);
    step(1'b1, mk(4,4,4,4), 1'b0);
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL sim_full: got %b want 1", bus.full); end
    step(1'b1, mk(9,9,9,9), 1'b1);
    n_cmp++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL sim_full_kept: got %b want 1", bus.full); end
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL sim_no_ovf: got %b want 0", bus.overflow_err); end
    n_cmp++; if (bus.rd_data !== mk(2,2,2,2)) begin n_err++; $display("FAIL sim_head: got %h want %h", bus.rd_data, mk(2,2,2,2)); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.rd_data !== mk(3,3,3,3)) begin n_err++; $display("FAIL sim_head2: got %h want %h", bus.rd_data, mk(3,3,3,3)); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL sim_not_full: got %b want 0", bus.full); end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL sim_partial_ready: got %b want 0", bus.vec_ready); end
    n_cmp++; if (bus.rd_data !== mk(9,9,9,9)) begin n_err++; $display("FAIL sim_wrap_head: got %h want %h", bus.rd_data, mk(9,9,9,9)); end
    step(1'b1, mk(10,10,10,10), 1'b0);
    n_cmp++; if (bus.vec_ready !== 1'b1) begin n_err++; $display("FAIL sim_third_ready: got %b want 1", bus.vec_ready); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.rd_data !== mk(10,10,10,10)) begin n_err++; $display("FAIL sim_third_c1: got %h want %h", bus.rd_data, mk(10,10,10,10)); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL sim_drained: got %b want 0", bus.vec_ready); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, mk(7,7,7,7), 1'b0);
    step(1'b1, mk(8,8,8,8), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b1, mk(6,6,6,6), 1'b0);
    step(1'b1, mk(5,5,5,5), 1'b0);
    step(1'b1, mk(4,4,4,4), 1'b0);
    n_cmp++; if (bus.vec_ready !== 1'b1) begin n_err++; $display("FAIL ar_pre_ready: got %b want 1", bus.vec_ready); end
    n_cmp++; if (bus.underflow_err !== ERR_EN) begin n_err++; $display("FAIL ar_pre_unf: got %b want %b", bus.underflow_err, ERR_EN); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL ar_ready: got %b want 0", bus.vec_ready); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL ar_full: got %b want 0", bus.full); end
    n_cmp++; if (bus.underflow_err !== 1'b0) begin n_err++; $display("FAIL ar_unf: got %b want 0", bus.underflow_err); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    step(1'b1, mk(20,21,22,23), 1'b0);
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL ar_first_ready: got %b want 0", bus.vec_ready); end
    step(1'b1, mk(24,25,26,27), 1'b0);
    n_cmp++; if (bus.vec_ready !== 1'b1) begin n_err++; $display("FAIL ar_commit_ready: got %b want 1", bus.vec_ready); end
    n_cmp++; if (bus.rd_data !== mk(20,21,22,23)) begin n_err++; $display("FAIL ar_head: got %h want %h", bus.rd_data, mk(20,21,22,23)); end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    n_cmp++; if (bus.vec_ready !== 1'b1) begin n_err++; $display("FAIL ar_gap_ready: got %b want 1", bus.vec_ready); end
    n_cmp++; if (bus.rd_data !== mk(24,25,26,27)) begin n_err++; $display("FAIL ar_gap_head: got %h want %h", bus.rd_data, mk(24,25,26,27)); end
    step(1'b0, '0, 1'b1);
    n_cmp++; if (bus.vec_ready !== 1'b0) begin n_err++; $display("FAIL ar_drained: got %b want 0", bus.vec_ready); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
